// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, state codes,
// condition codes and the registered control-strobe bundle.
package ctrl_pkg;

    localparam int OPC_W = 8;

    localparam logic [OPC_W-1:0] OP_RTYPE_MAX = 8'h16;
    localparam logic [OPC_W-1:0] OP_NOP       = 8'h17;
    localparam logic [OPC_W-1:0] OP_LOAD      = 8'h99;
    localparam logic [OPC_W-1:0] OP_STORE     = 8'hDA;
    localparam logic [OPC_W-1:0] OP_JCOND     = 8'hC4;
    localparam logic [OPC_W-1:0] OP_HALT      = 8'hFF;

    localparam logic [3:0] CC_EQ = 4'd0;
    localparam logic [3:0] CC_NE = 4'd1;
    localparam logic [3:0] CC_CS = 4'd2;
    localparam logic [3:0] CC_CC = 4'd3;
    localparam logic [3:0] CC_HI = 4'd4;
    localparam logic [3:0] CC_LS = 4'd5;
    localparam logic [3:0] CC_GT = 4'd6;
    localparam logic [3:0] CC_LE = 4'd7;
    localparam logic [3:0] CC_FS = 4'd8;
    localparam logic [3:0] CC_FC = 4'd9;
    localparam logic [3:0] CC_UC = 4'd14;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_FWAIT   = 4'd1,
        S_DECODE  = 4'd2,
        S_EXEC    = 4'd3,
        S_LD_ADDR = 4'd4,
        S_LD_WAIT = 4'd5,
        S_LD_WB   = 4'd6,
        S_ST      = 4'd7,
        S_JMP     = 4'd8,
        S_HALT    = 4'd9
    } state_e;

    typedef enum logic [2:0] {
        OPC_RTYPE = 3'd0,
        OPC_LOAD  = 3'd1,
        OPC_STORE = 3'd2,
        OPC_JCOND = 3'd3,
        OPC_HALT  = 3'd4,
        OPC_NOP   = 3'd5
    } op_class_e;

    typedef struct packed {
        logic pc_en;
        logic pc_load;
        logic addr_sel;
        logic mem_we;
        logic reg_we;
        logic wb_sel;
        logic halted;
    } ctrl_t;

    // Undefined opcodes fall into the NOP class so they only advance the PC.
    function automatic op_class_e decode_op(input logic [OPC_W-1:0] op);
        op_class_e cls;
        if (op <= OP_RTYPE_MAX) begin
            cls = OPC_RTYPE;
        end else begin
            case (op)
                OP_NOP:   cls = OPC_NOP;
                OP_LOAD:  cls = OPC_LOAD;
                OP_STORE: cls = OPC_STORE;
                OP_JCOND: cls = OPC_JCOND;
                OP_HALT:  cls = OPC_HALT;
                default:  cls = OPC_NOP;
            endcase
        end
        return cls;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Jump condition evaluator: maps a 4-bit condition code and the ALU flags
// {C,L,F,Z,N} to a taken decision.
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [4:0] flags,
    output logic       taken
);

    logic c_s, l_s, f_s, z_s, n_s;

    assign {c_s, l_s, f_s, z_s, n_s} = flags;

    // Condition-code lookup; reserved codes are never taken.
    always_comb begin
        taken = 1'b0;
        case (cond)
            CC_EQ:   taken = z_s;
            CC_NE:   taken = ~z_s;
            CC_CS:   taken = c_s;
            CC_CC:   taken = ~c_s;
            CC_HI:   taken = l_s;
            CC_LS:   taken = ~l_s;
            CC_GT:   taken = n_s;
            CC_LE:   taken = ~n_s;
            CC_FS:   taken = f_s;
            CC_FC:   taken = ~f_s;
            CC_UC:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller for the 16-bit load/store CPU. Outputs are registered
// from the next state so they track the current state with no glitch path.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [4:0]        flags,
    input  logic              run,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] alu_instr,
    output logic              pc_en,
    output logic              pc_load,
    output logic              addr_sel,
    output logic              mem_we,
    output logic              reg_we,
    output logic              wb_sel,
    output logic              halted,
    output logic [3:0]        state
);

    localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

    state_e            state_r, state_nxt_s;
    logic [DATA_W-1:0] ir_r, ir_nxt_s;
    logic [1:0]        cnt_r, cnt_nxt_s;
    ctrl_t             ctrl_r, ctrl_nxt_s;
    logic [DATA_W-1:0] alu_instr_r, alu_nxt_s;
    op_class_e         cls_cur_s, cls_nxt_s;
    logic              taken_s;

    assign cls_cur_s = decode_op(ir_r[DATA_W-1 -: OPC_W]);
    assign cls_nxt_s = decode_op(ir_nxt_s[DATA_W-1 -: OPC_W]);

    // ir is stable from DECODE into JMP, so the decision uses flags held before JMP entry.
    cond_eval u_cond_eval (
        .cond  (ir_nxt_s[7:4]),
        .flags (flags),
        .taken (taken_s)
    );

    // Next-state, instruction latch and shared latency counter.
    always_comb begin
        state_nxt_s = state_r;
        ir_nxt_s    = ir_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            S_FETCH: begin
                if (run) state_nxt_s = S_FWAIT;
                else     state_nxt_s = S_FETCH;
            end
            S_FWAIT: begin
                if (cnt_r == LAST_CNT) begin
                    ir_nxt_s    = mem_rdata;
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = S_DECODE;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            S_DECODE: begin
                case (cls_cur_s)
                    OPC_RTYPE: state_nxt_s = S_EXEC;
                    OPC_LOAD:  state_nxt_s = S_LD_ADDR;
                    OPC_STORE: state_nxt_s = S_ST;
                    OPC_JCOND: state_nxt_s = S_JMP;
                    OPC_HALT:  state_nxt_s = S_HALT;
                    default:   state_nxt_s = S_FETCH;
                endcase
            end
            S_LD_ADDR: state_nxt_s = S_LD_WAIT;
            S_LD_WAIT: begin
                if (cnt_r == LAST_CNT) begin
                    cnt_nxt_s   = 2'd0;
                    state_nxt_s = S_LD_WB;
                end else begin
                    cnt_nxt_s = cnt_r + 2'd1;
                end
            end
            S_EXEC, S_LD_WB, S_ST, S_JMP: state_nxt_s = S_FETCH;
            S_HALT:  state_nxt_s = S_HALT;
            default: state_nxt_s = S_FETCH;
        endcase
    end

    // Control strobes for the state being entered.
    always_comb begin
        ctrl_nxt_s = '0;
        case (state_nxt_s)
            S_DECODE: ctrl_nxt_s.pc_en = (cls_nxt_s == OPC_NOP);
            S_EXEC: begin
                ctrl_nxt_s.reg_we = 1'b1;
                ctrl_nxt_s.pc_en  = 1'b1;
            end
            S_LD_ADDR, S_LD_WAIT: ctrl_nxt_s.addr_sel = 1'b1;
            S_LD_WB: begin
                ctrl_nxt_s.reg_we = 1'b1;
                ctrl_nxt_s.wb_sel = 1'b1;
                ctrl_nxt_s.pc_en  = 1'b1;
            end
            S_ST: begin
                ctrl_nxt_s.addr_sel = 1'b1;
                ctrl_nxt_s.mem_we   = 1'b1;
                ctrl_nxt_s.pc_en    = 1'b1;
            end
            S_JMP: begin
                ctrl_nxt_s.pc_load = taken_s;
                ctrl_nxt_s.pc_en   = ~taken_s;
            end
            S_HALT:  ctrl_nxt_s.halted = 1'b1;
            default: ctrl_nxt_s = '0;
        endcase
    end

    // The ALU sees the instruction only while it is producing a result.
    always_comb begin
        alu_nxt_s = '0;
        if (state_nxt_s == S_EXEC || state_nxt_s == S_LD_WB) begin
            alu_nxt_s = ir_nxt_s;
        end else begin
            alu_nxt_s = '0;
        end
    end

    // State, instruction, counter and output registers; reset clears all outputs at once.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state_r     <= S_FETCH;
            ir_r        <= '0;
            cnt_r       <= 2'd0;
            ctrl_r      <= '0;
            alu_instr_r <= '0;
        end else begin
            state_r     <= state_nxt_s;
            ir_r        <= ir_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ctrl_r      <= ctrl_nxt_s;
            alu_instr_r <= alu_nxt_s;
        end
    end

    assign ir        = ir_r;
    assign alu_instr = alu_instr_r;
    assign pc_en     = ctrl_r.pc_en;
    assign pc_load   = ctrl_r.pc_load;
    assign addr_sel  = ctrl_r.addr_sel;
    assign mem_we    = ctrl_r.mem_we;
    assign reg_we    = ctrl_r.reg_we;
    assign wb_sel    = ctrl_r.wb_sel;
    assign halted    = ctrl_r.halted;
    assign state     = state_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with one instance at MEM_LAT=1 and one
// at MEM_LAT=3, sharing clock, reset and flags.
module tb_multicycle_ctrl;

    logic        clock = 1'b0;
    logic        Reset = 1'b0;
    logic [4:0]  flags = 5'd0;
    logic        run1 = 1'b0, run3 = 1'b0;
    logic [15:0] rdata1 = 16'd0, rdata3 = 16'd0;

    logic [15:0] ir1, alu1, ir3, alu3;
    logic        pc_en1, pc_load1, addr_sel1, mem_we1, reg_we1, wb_sel1, halted1;
    logic        pc_en3, pc_load3, addr_sel3, mem_we3, reg_we3, wb_sel3, halted3;
    logic [3:0]  state1, state3;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    multicycle_ctrl #(.DATA_W(16), .MEM_LAT(1)) u1 (
        .clock(clock), .Reset(Reset), .mem_rdata(rdata1), .flags(flags), .run(run1),
        .ir(ir1), .alu_instr(alu1), .pc_en(pc_en1), .pc_load(pc_load1),
        .addr_sel(addr_sel1), .mem_we(mem_we1), .reg_we(reg_we1), .wb_sel(wb_sel1),
        .halted(halted1), .state(state1)
    );

    multicycle_ctrl #(.DATA_W(16), .MEM_LAT(3)) u3 (
        .clock(clock), .Reset(Reset), .mem_rdata(rdata3), .flags(flags), .run(run3),
        .ir(ir3), .alu_instr(alu3), .pc_en(pc_en3), .pc_load(pc_load3),
        .addr_sel(addr_sel3), .mem_we(mem_we3), .reg_we(reg_we3), .wb_sel(wb_sel3),
        .halted(halted3), .state(state3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [6:0] strobes1();
        return {pc_en1, pc_load1, addr_sel1, mem_we1, reg_we1, wb_sel1, halted1};
    endfunction

    // Runs one instruction on the MEM_LAT=3 instance and tallies strobes until FETCH.
    task automatic exec3(input logic [15:0] instr, input logic [4:0] fl,
                         output int ticks, output int n_pc_en, output int n_pc_load,
                         output int n_reg_we, output int n_mem_we,
                         output int n_fw, output int n_lw);
        rdata3 = instr;
        flags  = fl;
        run3   = 1'b1;
        ticks = 0; n_pc_en = 0; n_pc_load = 0; n_reg_we = 0; n_mem_we = 0; n_fw = 0; n_lw = 0;
        do begin
            tick();
            if (ticks == 0) run3 = 1'b0;
            ticks++;
            n_pc_en   += int'(pc_en3);
            n_pc_load += int'(pc_load3);
            n_reg_we  += int'(reg_we3);
            n_mem_we  += int'(mem_we3);
            n_fw      += int'(state3 == 4'd1);
            n_lw      += int'(state3 == 4'd5);
        end while (state3 != 4'd0 && ticks < 40);
    endtask

    // Starts an instruction on the MEM_LAT=1 instance and advances n cycles.
    task automatic start1(input logic [15:0] instr, input logic [4:0] fl, input int n);
        rdata1 = instr;
        flags  = fl;
        run1   = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            run1 = 1'b0;
        end
    endtask

    task automatic jmp1(input string tag, input logic [15:0] instr, input logic [4:0] fl,
                        input logic exp_taken);
        start1(instr, fl, 3);
        check({tag, "_state"}, state1, 32'd8);
        check({tag, "_pc_load_en"}, {pc_load1, pc_en1}, {exp_taken, ~exp_taken});
        tick();
        check({tag, "_back"}, state1, 32'd0);
    endtask

    task automatic apply_reset();
        Reset = 1'b0;
        @(negedge clock);
        Reset = 1'b1;
        tick();
    endtask

    initial begin
        int t, npe, npl, nrw, nmw, nfw, nlw, cnt;

        #12;
        check("rst_state1", state1, 32'd0);
        check("rst_out1", {ir1, alu1, 9'(strobes1())}, 32'd0);
        check("rst_out3", {ir3, alu3, pc_en3, pc_load3, addr_sel3, mem_we3, reg_we3, wb_sel3, halted3},
              32'd0);
        @(negedge clock);
        Reset = 1'b1;
        tick();

        // R-type at MEM_LAT=1: 0 -> 1 -> 2 -> 3 -> 0
        start1(16'h0012, 5'd0, 1);
        check("rt_s1", state1, 32'd1);
        tick();
        check("rt_s2", {state1, ir1}, {4'd2, 16'h0012});
        tick();
        check("rt_exec", {state1, reg_we1, wb_sel1, pc_en1, alu1}, {4'd3, 3'b101, 16'h0012});
        tick();
        check("rt_done", {state1, alu1, 9'(strobes1())}, {4'd0, 16'h0000, 9'd0});

        // MEM_LAT=3 sequences
        exec3(16'h9903, 5'd0, t, npe, npl, nrw, nmw, nfw, nlw);
        check("ld_cycles", t, 32'd10);
        check("ld_waits", {nfw[7:0], nlw[7:0]}, {8'd3, 8'd3});
        check("ld_strobes", {npe[7:0], npl[7:0], nrw[7:0], nmw[7:0]}, 32'h01000100);
        exec3(16'h1634, 5'd0, t, npe, npl, nrw, nmw, nfw, nlw);
        check("rt16_cycles", t, 32'd6);
        check("rt16_strobes", {npe[7:0], npl[7:0], nrw[7:0], nmw[7:0]}, 32'h01000100);
        exec3(16'hDA21, 5'd0, t, npe, npl, nrw, nmw, nfw, nlw);
        check("st3_cycles", t, 32'd6);
        check("st3_strobes", {npe[7:0], npl[7:0], nrw[7:0], nmw[7:0]}, 32'h01000001);
        exec3(16'h1700, 5'd0, t, npe, npl, nrw, nmw, nfw, nlw);
        check("nop_cycles", t, 32'd5);
        exec3(16'h5500, 5'd0, t, npe, npl, nrw, nmw, nfw, nlw);
        check("und3_cycles", t, 32'd5);
        check("und3_strobes", {npe[7:0], npl[7:0], nrw[7:0], nmw[7:0]}, 32'h01000000);
        exec3(16'hC4E0, 5'd0, t, npe, npl, nrw, nmw, nfw, nlw);
        check("juc3_cycles", t, 32'd6);
        check("juc3_strobes", {npe[7:0], npl[7:0]}, 16'h0001);

        // Jumps at MEM_LAT=1; flags are {C,L,F,Z,N}
        jmp1("jeq_z1", 16'hC400, 5'b00010, 1'b1);
        jmp1("jeq_z0", 16'hC400, 5'b00000, 1'b0);
        jmp1("jne_z0", 16'hC410, 5'b00000, 1'b1);
        jmp1("jhi_l1", 16'hC440, 5'b01000, 1'b1);
        jmp1("jgt_n0", 16'hC460, 5'b11110, 1'b0);
        jmp1("juc_f0", 16'hC4E0, 5'b00000, 1'b1);
        jmp1("jnv_f1", 16'hC4F0, 5'b11111, 1'b0);

        // Undefined opcode pulses pc_en in DECODE only
        start1(16'h5500, 5'd0, 2);
        check("und_dec", {state1, 9'(strobes1())}, {4'd2, 9'b001000000});
        tick();
        check("und_back", state1, 32'd0);

        // Store interrupted by reset mid-cycle
        start1(16'hDA21, 5'd0, 3);
        check("st_cycle", {state1, 9'(strobes1())}, {4'd7, 9'b001011000});
        #2;
        Reset = 1'b0;
        #1;
        check("st_rst", {state1, ir1, 9'(strobes1())}, 32'd0);
        @(negedge clock);
        Reset = 1'b1;
        tick();

        // Halt holds until reset
        start1(16'hFF00, 5'd0, 3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (state1 == 4'd9 && strobes1() == 7'b0000001) cnt++;
            tick();
        end
        check("halt_hold", cnt, 32'd20);
        Reset = 1'b0;
        #1;
        check("halt_rst", {state1, 9'(strobes1())}, 32'd0);
        @(negedge clock);
        Reset = 1'b1;
        tick();

        // Idle with run low, then start
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (state1 != 4'd0 || strobes1() != 7'd0) cnt++;
        end
        check("idle", cnt, 32'd0);
        start1(16'h1700, 5'd0, 1);
        check("idle_start", state1, 32'd1);
        tick();
        check("idle_nop", {state1, pc_en1}, {4'd2, 1'b1});
        tick();
        check("idle_done", state1, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
